csr_timer_bank: RTL and testbench
=================================

CSR_TIMER_BANK -- requirements
Module: csr_timer_bank

Interface
REQ-001 Parameters SHALL be:
- NUM_TIMERS, default 4, number of independent timer channels (1..8).
- CNT_WIDTH, default 32, counter width in bits (8..32).
- CSR_BASE, default 14'h0041, CSR number of timer 0 TCFG.
REQ-002 Per-timer CSR numbers SHALL be:
- TCFG(i) = CSR_BASE+4*i
- TVAL(i) = CSR_BASE+4*i+1
- TICLR(i) = CSR_BASE+4*i+2
REQ-003 Shared CSR numbers SHALL be CTRL = CSR_BASE+32 and STAT = CSR_BASE+33.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- resetn  in  1  one clock; reset is asynchronous and active-low.
- freeze  in  1  debug halt: prescaler and all counters hold.
- csr_we  in  1  CSR write strobe.
- csr_num  in  14  CSR number.
- csr_wmask  in  32  per-bit write mask.
- csr_wvalue  in  32  write data.
- csr_rvalue  out  32  combinational read data for csr_num.
- irq_vec  out  NUM_TIMERS  per-timer interrupt = pending & ie.
- irq_any  out  1  OR-reduction of irq_vec.

Function
REQ-005 Every CSR write SHALL update only masked bits: new = (wmask & wvalue) | (~wmask & old).
REQ-006 TCFG layout SHALL be bit0 EN, bit1 PERIODIC, bits[CNT_WIDTH-1:2] INITVAL; bits above CNT_WIDTH SHALL read 0 and ignore writes.
REQ-007 CTRL layout SHALL be bits[NUM_TIMERS-1:0] IE and bits[23:16] PRESCALE; all other bits SHALL read 0.
REQ-008 STAT SHALL be read-only, with bits[NUM_TIMERS-1:0] = pending; writes to STAT SHALL be ignored.
REQ-009 TVAL(i) SHALL read the current counter of timer i, zero-extended to 32 bits; writes to TVAL SHALL be ignored.
REQ-010 TICLR(i) SHALL always read 0; a write with wmask[0]&wvalue[0]=1 SHALL clear pending[i].
REQ-011 Reads of unmapped CSR numbers, including unused channel slots, SHALL return 32'h0.
REQ-012 The prescaler SHALL be a free counter psc 0..PRESCALE.
- tick is asserted while psc==PRESCALE and freeze=0.
- psc wraps to 0 on tick and holds while freeze=1.
- PRESCALE=0 SHALL give a tick every unfrozen cycle.
REQ-013 A TCFG(i) write whose merged value has EN=1 SHALL load cnt[i] = {merged INITVAL, 2'b00} at that edge; this load SHALL override any tick in the same cycle.
REQ-014 On each tick, if EN[i]=1 and cnt[i] != all-ones:
- cnt[i]==0 and PERIODIC=1: reload {INITVAL,2'b00}.
- otherwise: decrement by 1 (modulo 2^CNT_WIDTH).
REQ-015 A one-shot timer SHALL therefore wrap from 0 to all-ones and stop there until reloaded.
REQ-016 Expiry event SHALL be defined as tick & EN[i] & cnt[i]==0; it SHALL set pending[i] at the same edge.
REQ-017 If an expiry event and a TICLR(i) clear occur in the same cycle, set SHALL win and pending[i] SHALL be 1.
REQ-018 Clearing EN SHALL freeze cnt[i] at its current value; pending[i] SHALL remain unchanged.
REQ-019 Changing PRESCALE SHALL NOT reset psc; if psc > new PRESCALE, psc SHALL count up and wrap through all-ones to 0 without generating a tick at the wrap.
REQ-020 irq_vec and irq_any SHALL be combinational from the pending and IE flops, with no added latency.

Reset
REQ-021 When resetn=0, the block SHALL asynchronously set:
- EN, PERIODIC, INITVAL, IE, PRESCALE, psc and pending = 0.
- every cnt[i] = all-ones.
- irq_vec = 0 and irq_any = 0.
REQ-022 Reset asserted mid-count SHALL abort all timers; after reset no expiry SHALL occur until TCFG is rewritten with EN=1.

Verification
REQ-023 Reset, then read TVAL(0) -> 32'hFFFFFFFF (CNT_WIDTH=32); STAT -> 0; irq_any=0.
REQ-024 CTRL IE[0]=1, PRESCALE=0; write TCFG(0)=0x11 (INITVAL=4, one-shot) -> TVAL reads 16, 15, ... 0, then FFFFFFFF and holds. pending[0] rises on the edge leaving 0, and irq_vec[0]=1 from then on.
REQ-025 Same setup with TCFG(0)=0x13 (periodic) -> TVAL sequence 16..0,16..0. pending is set at each 0, cleared by TICLR(0)=1, and set again at the next 0.
REQ-026 Issue a TICLR(0) write in the exact cycle of an expiry -> pending[0]=1 after that edge.
REQ-027 PRESCALE=3 with freeze held high for 10 cycles mid-count -> TVAL decrements every 4 unfrozen cycles and is unchanged while frozen.
REQ-028 NUM_TIMERS=2: TCFG(1) write with wmask=0x1 on a running timer -> only EN changes, INITVAL is preserved, and timer 0 is unaffected.

Source files
------------

// File: rtl/csr_timer_bank.sv
// Bank of CSR-mapped down-counting timers sharing one prescaler.
// Each channel runs one-shot or periodic and raises a maskable pending flag on expiry.
module csr_timer_bank #(
    parameter int          NUM_TIMERS = 4,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [13:0] CSR_BASE   = 14'h0041
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  freeze,
    input  logic                  csr_we,
    input  logic [13:0]           csr_num,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wvalue,
    output logic [31:0]           csr_rvalue,
    output logic [NUM_TIMERS-1:0] irq_vec,
    output logic                  irq_any
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;

    logic [CNT_WIDTH-1:0]  tcfg_q [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  tcfg_d [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  cnt_q  [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  cnt_d  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] ie_q, ie_d, pend_q, pend_d;
    logic [7:0]            presc_q, presc_d, psc_q, psc_d;

    logic [13:0]           off;
    logic                  in_win, tmr_hit, ctrl_hit, stat_hit, tick;
    logic [2:0]            slot;
    logic [1:0]            sub;
    logic [31:0]           ctrl_word, ctrl_mrg;
    logic [31:0]           tcfg_mrg [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] sel, tcfg_wr, clr_wr, expire;

    // Address decode relative to the base; the channel window spans 8 slots of 4 CSRs.
    always_comb begin
        off      = csr_num - CSR_BASE;
        in_win   = (csr_num >= CSR_BASE);
        slot     = off[4:2];
        sub      = off[1:0];
        tmr_hit  = in_win && (off[13:5] == 9'd0);
        ctrl_hit = in_win && (off == 14'd32);
        stat_hit = in_win && (off == 14'd33);
    end

    // psc is only cleared by a tick, so lowering PRESCALE below psc wraps through 8'hFF.
    always_comb begin
        tick  = (psc_q == presc_q) && !freeze;
        psc_d = psc_q;
        if (tick) begin
            psc_d = 8'd0;
        end else if (!freeze) begin
            psc_d = psc_q + 8'd1;
        end
    end

    always_comb begin
        ctrl_word = 32'(ie_q) | {8'd0, presc_q, 16'd0};
        ctrl_mrg  = (csr_wmask & csr_wvalue) | (~csr_wmask & ctrl_word);
        for (int i = 0; i < NUM_TIMERS; i++) begin
            sel[i]      = tmr_hit && (slot == 3'(i));
            tcfg_mrg[i] = (csr_wmask & csr_wvalue) | (~csr_wmask & 32'(tcfg_q[i]));
            tcfg_wr[i]  = csr_we && sel[i] && (sub == 2'd0);
            clr_wr[i]   = csr_we && sel[i] && (sub == 2'd2) && csr_wmask[0] && csr_wvalue[0];
            expire[i]   = tick && tcfg_q[i][0] && (cnt_q[i] == '0);
        end
    end

    always_comb begin
        ie_d    = ie_q;
        presc_d = presc_q;
        pend_d  = pend_q;
        if (csr_we && ctrl_hit) begin
            ie_d    = ctrl_mrg[NUM_TIMERS-1:0];
            presc_d = ctrl_mrg[23:16];
        end
        for (int i = 0; i < NUM_TIMERS; i++) begin
            tcfg_d[i] = tcfg_q[i];
            cnt_d[i]  = cnt_q[i];
            if (tcfg_wr[i]) begin
                tcfg_d[i] = tcfg_mrg[i][CNT_WIDTH-1:0];
            end
            // An enabling TCFG write reloads the counter and takes priority over a tick.
            if (tcfg_wr[i] && tcfg_mrg[i][0]) begin
                cnt_d[i] = {tcfg_mrg[i][CNT_WIDTH-1:2], 2'b00};
            end else if (tick && tcfg_q[i][0] && (cnt_q[i] != CNT_ONES)) begin
                if ((cnt_q[i] == '0) && tcfg_q[i][1]) begin
                    cnt_d[i] = {tcfg_q[i][CNT_WIDTH-1:2], 2'b00};
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                end
            end
            if (clr_wr[i]) begin
                pend_d[i] = 1'b0;
            end
            if (expire[i]) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ie_q    <= '0;
            presc_q <= '0;
            psc_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                tcfg_q[i] <= '0;
                cnt_q[i]  <= CNT_ONES;
            end
        end else begin
            ie_q    <= ie_d;
            presc_q <= presc_d;
            psc_q   <= psc_d;
            pend_q  <= pend_d;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                tcfg_q[i] <= tcfg_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_comb begin
        csr_rvalue = 32'h0;
        if (tmr_hit) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (sel[i]) begin
                    case (sub)
                        2'd0:    csr_rvalue = 32'(tcfg_q[i]);
                        2'd1:    csr_rvalue = 32'(cnt_q[i]);
                        default: csr_rvalue = 32'h0;
                    endcase
                end
            end
        end else if (ctrl_hit) begin
            csr_rvalue = ctrl_word;
        end else if (stat_hit) begin
            csr_rvalue = 32'(pend_q);
        end
    end

    assign irq_vec = pend_q & ie_q;
    assign irq_any = |irq_vec;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed and randomized checks of csr_timer_bank against a behavioural model of the timer rules.
module tb_csr_timer_bank;
    localparam int          NT   = 2;
    localparam logic [13:0] BASE = 14'h0041;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          freeze = 1'b0;
    logic          csr_we = 1'b0;
    logic [13:0]   csr_num = 14'h0;
    logic [31:0]   csr_wmask = 32'h0;
    logic [31:0]   csr_wvalue = 32'h0;
    logic [31:0]   csr_rvalue;
    logic [NT-1:0] irq_vec;
    logic          irq_any;

    int tests = 0;
    int fails = 0;

    csr_timer_bank #(.NUM_TIMERS(NT), .CNT_WIDTH(32), .CSR_BASE(BASE)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .freeze     (freeze),
        .csr_we     (csr_we),
        .csr_num    (csr_num),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .csr_rvalue (csr_rvalue),
        .irq_vec    (irq_vec),
        .irq_any    (irq_any)
    );

    always #5 clk = ~clk;

    // Reference model state: channel fields kept as whole words, decoded with arithmetic.
    logic [31:0]   m_cfg [NT];
    logic [31:0]   m_cnt [NT];
    logic [NT-1:0] m_pend, m_ie;
    logic [7:0]    m_presc, m_psc;

    localparam logic [13:0] CTRL = BASE + 14'd32;
    localparam logic [13:0] STAT = BASE + 14'd33;

    function automatic logic [13:0] a_cfg(input int i);
        return BASE + 14'(4 * i);
    endfunction
    function automatic logic [13:0] a_val(input int i);
        return BASE + 14'(4 * i + 1);
    endfunction
    function automatic logic [13:0] a_clr(input int i);
        return BASE + 14'(4 * i + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_cfg[i] = 32'h0;
            m_cnt[i] = 32'hFFFF_FFFF;
        end
        m_pend  = '0;
        m_ie    = '0;
        m_presc = 8'd0;
        m_psc   = 8'd0;
    endtask

    task automatic model_step(input logic we, input logic [13:0] num, input logic [31:0] mask,
                              input logic [31:0] val, input logic frz);
        int          off;
        bit          tick;
        logic [31:0] ctrl_old, ctrl_new;
        off  = int'(num) - int'(BASE);
        tick = (m_psc == m_presc) && !frz;
        for (int i = 0; i < NT; i++) begin
            bit en, per, expired;
            en      = m_cfg[i][0];
            per     = m_cfg[i][1];
            expired = tick && en && (m_cnt[i] == 32'd0);
            if (tick && en && m_cnt[i] != 32'hFFFF_FFFF) begin
                if (m_cnt[i] == 32'd0 && per) m_cnt[i] = (m_cfg[i] >> 2) << 2;
                else m_cnt[i] = m_cnt[i] - 32'd1;
            end
            if (we && off == 4 * i) begin
                m_cfg[i] = (mask & val) | (~mask & m_cfg[i]);
                if (m_cfg[i][0]) m_cnt[i] = (m_cfg[i] >> 2) << 2;
            end
            if (we && off == 4 * i + 2 && mask[0] && val[0]) m_pend[i] = 1'b0;
            if (expired) m_pend[i] = 1'b1;
        end
        if (we && off == 32) begin
            ctrl_old = {8'd0, m_presc, 14'd0, m_ie};
            ctrl_new = (mask & val) | (~mask & ctrl_old);
            m_ie     = ctrl_new[NT-1:0];
            m_presc  = ctrl_new[23:16];
        end
        if (!frz) m_psc = tick ? 8'd0 : m_psc + 8'd1;
    endtask

    function automatic logic [31:0] model_rd(input logic [13:0] num);
        int off;
        off = int'(num) - int'(BASE);
        if (off >= 0 && off < 4 * NT) begin
            if (off % 4 == 0) return m_cfg[off / 4];
            if (off % 4 == 1) return m_cnt[off / 4];
            return 32'h0;
        end
        if (off == 32) return {8'd0, m_presc, 14'd0, m_ie};
        if (off == 33) return 32'(m_pend);
        return 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic [13:0] num, input logic [31:0] mask,
                       input logic [31:0] val, input logic frz);
        csr_we     = we;
        csr_num    = num;
        csr_wmask  = mask;
        csr_wvalue = val;
        freeze     = frz;
        model_step(we, num, mask, val, frz);
        @(posedge clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] val);
        cyc(1'b1, num, 32'hFFFF_FFFF, val, 1'b0);
    endtask

    task automatic idle(input logic frz);
        cyc(1'b0, 14'h0, 32'h0, 32'h0, frz);
    endtask

    task automatic rd(input logic [13:0] num);
        csr_num = num;
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [13:0] num);
        rd(num);
        check(tag, csr_rvalue, model_rd(num));
    endtask

    task automatic chk_irq();
        check("irq_vec", 32'(irq_vec), 32'(m_pend & m_ie));
        check("irq_any", 32'(irq_any), 32'(|(m_pend & m_ie)));
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Values held during reset
        rd(a_val(0));  check("rst_tval0", csr_rvalue, 32'hFFFF_FFFF);
        rd(STAT);      check("rst_stat", csr_rvalue, 32'h0);
        check("rst_irq_any", 32'(irq_any), 32'h0);
        resetn = 1'b1;

        // One-shot countdown 16..0, then wrap to all-ones and hold
        wr(CTRL, 32'h0000_0001);
        wr(a_cfg(0), 32'h11);
        rd(a_val(0)); check("os_load", csr_rvalue, 32'd16);
        for (int k = 15; k >= 0; k--) begin
            idle(1'b0);
            rd(a_val(0)); check("os_count", csr_rvalue, 32'(k));
        end
        check("os_irq_before", 32'(irq_vec), 32'h0);
        idle(1'b0);
        rd(a_val(0)); check("os_wrap", csr_rvalue, 32'hFFFF_FFFF);
        check("os_irq_set", 32'(irq_vec), 32'h1);
        rd(STAT); check("os_stat", csr_rvalue, 32'h1);
        repeat (3) idle(1'b0);
        rd(a_val(0)); check("os_hold", csr_rvalue, 32'hFFFF_FFFF);
        check("os_irq_hold", 32'(irq_any), 32'h1);

        // Periodic reload, clear and re-set of pending
        wr(a_clr(0), 32'h1);
        rd(STAT); check("clr_stat", csr_rvalue, 32'h0);
        wr(a_cfg(0), 32'h13);
        for (int k = 15; k >= 0; k--) idle(1'b0);
        rd(a_val(0)); check("per_zero", csr_rvalue, 32'd0);
        idle(1'b0);
        rd(a_val(0)); check("per_reload", csr_rvalue, 32'd16);
        rd(STAT); check("per_pend", csr_rvalue, 32'h1);
        wr(a_clr(0), 32'h1);
        rd(STAT); check("per_clr", csr_rvalue, 32'h0);
        rd(a_val(0)); check("per_15", csr_rvalue, 32'd15);
        for (int k = 14; k >= 0; k--) idle(1'b0);
        rd(STAT); check("per_pend_low_at0", csr_rvalue, 32'h0);
        // Clear issued in the same cycle as expiry: set wins
        wr(a_clr(0), 32'h1);
        rd(STAT); check("setwins_stat", csr_rvalue, 32'h1);
        rd(a_val(0)); check("setwins_reload", csr_rvalue, 32'd16);
        chk_irq();

        // Prescale 3 with a freeze window
        wr(CTRL, 32'h0003_0001);
        wr(a_cfg(0), (32'd20 << 2) | 32'h1);
        rd(a_val(0)); check("psc_load", csr_rvalue, 32'd80);
        repeat (5) idle(1'b0);
        rd(a_val(0)); check("psc_79", csr_rvalue, 32'd79);
        for (int k = 0; k < 10; k++) begin
            idle(1'b1);
            rd(a_val(0)); check("frz_hold", csr_rvalue, 32'd79);
        end
        idle(1'b0);
        rd(a_val(0)); check("unfrz_1", csr_rvalue, 32'd79);
        idle(1'b0);
        rd(a_val(0)); check("unfrz_2", csr_rvalue, 32'd78);
        repeat (4) idle(1'b0);
        rd(a_val(0)); check("unfrz_6", csr_rvalue, 32'd77);

        // Masked TCFG(1) write touches only EN
        wr(a_cfg(1), (32'd10 << 2) | 32'h1);
        repeat (6) idle(1'b0);
        cyc(1'b1, a_cfg(1), 32'h1, 32'h0, 1'b0);
        rd(a_cfg(1)); check("mask_cfg1", csr_rvalue, 32'h28);
        chk_rd("mask_tval1", a_val(1));
        chk_rd("mask_tval0", a_val(0));
        repeat (8) idle(1'b0);
        chk_rd("en_off_frozen", a_val(1));
        cyc(1'b1, a_cfg(1), 32'h1, 32'hFFFF_FFFF, 1'b0);
        rd(a_val(1)); check("mask_reen", csr_rvalue, 32'd40);

        // Read-only, ignored and unmapped locations
        cyc(1'b1, a_val(0), 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        chk_rd("tval_wr_ignored", a_val(0));
        cyc(1'b1, STAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk_rd("stat_wr_ignored", STAT);
        rd(a_clr(0)); check("ticlr_reads0", csr_rvalue, 32'h0);
        rd(a_cfg(2)); check("unused_slot", csr_rvalue, 32'h0);
        rd(BASE + 14'd3); check("offset3", csr_rvalue, 32'h0);
        rd(BASE - 14'd1); check("below_base", csr_rvalue, 32'h0);
        rd(BASE + 14'd34); check("above_stat", csr_rvalue, 32'h0);
        rd(CTRL); check("ctrl_rd", csr_rvalue, 32'h0003_0001);

        // Reset in the middle of a count
        wr(CTRL, 32'h0000_0003);
        wr(a_cfg(0), 32'h9);
        repeat (3) idle(1'b0);
        #2 resetn = 1'b0;
        model_reset();
        rd(a_val(0)); check("midrst_tval0", csr_rvalue, 32'hFFFF_FFFF);
        rd(STAT); check("midrst_stat", csr_rvalue, 32'h0);
        check("midrst_irq", 32'(irq_any), 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (30) idle(1'b0);
        rd(STAT); check("postrst_no_expiry", csr_rvalue, 32'h0);
        chk_rd("postrst_tval0", a_val(0));

        // Randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            int          r, t;
            logic        we, frz;
            logic [13:0] num;
            logic [31:0] mask, val;
            r    = int'($urandom_range(0, 99));
            t    = int'($urandom_range(0, NT - 1));
            we   = 1'b1;
            num  = 14'h0;
            mask = 32'hFFFF_FFFF;
            val  = 32'h0;
            if (r < 8) begin
                num = a_cfg(t);
                val = (32'($urandom_range(0, 6)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) mask = $urandom;
            end else if (r < 12) begin
                num = a_clr(t);
                val = 32'($urandom_range(0, 1));
            end else if (r < 15) begin
                num = CTRL;
                val = (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 3));
            end else if (r < 18) begin
                num  = BASE - 14'd2 + 14'($urandom_range(0, 38));
                mask = $urandom;
                val  = $urandom;
                if (num == a_cfg(0) || num == a_cfg(1) || num == CTRL) we = 1'b0;
            end else begin
                we = 1'b0;
            end
            frz = ($urandom_range(0, 9) == 0);
            cyc(we, num, mask, val, frz);
            chk_rd("rnd_any", BASE - 14'd2 + 14'($urandom_range(0, 38)));
            chk_rd("rnd_tval", a_val(t));
            chk_irq();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
